aes_enc_iter: RTL and testbench

//  Iterative AES-128 encryptor, one round per clock. Transmit-side counterpart of the iterative decoder.

---
 rtl/aes_pkg.sv | 65 ++++++
 rtl/aes_enc_round.sv | 31 +++
 rtl/aes_key_shedualing.sv | 29 ++
 rtl/aes_mixw.sv | 21 ++
 rtl/aes_sbox.sv | 11 +
 rtl/aes_enc_iter.sv | 104 ++++++++++
 tb/tb_aes_enc_iter.sv | 300 ++++++++++++++++++++++++++++++
 7 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants, byte-map helpers, S-box table and xtime.
// Optional feature macro used by the encryptor top: AES_ENC_LASTKEY_EN.
package aes_pkg;

  localparam int         NR        = 10;
  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [3:0] FSM_DONE  = 4'd11;

  typedef logic [127:0] state_t;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_R1    = 4'd1,
    ST_R2    = 4'd2,
    ST_R3    = 4'd3,
    ST_R4    = 4'd4,
    ST_R5    = 4'd5,
    ST_R6    = 4'd6,
    ST_R7    = 4'd7,
    ST_R8    = 4'd8,
    ST_R9    = 4'd9,
    ST_FINAL = 4'(NR),
    ST_DONE  = FSM_DONE
  } fsm_t;

  // Byte s[r][c] sits at bus[32*c + 8*r +: 8]; column c is bus[32*c +: 32].
  function automatic int byte_lsb(int r, int c);
    return 32 * c + 8 * r;
  endfunction

  function automatic int col_lsb(int c);
    return 32 * c;
  endfunction

  function automatic logic [7:0] xtime(logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Entry i of the forward S-box lives at SBOX_TBL[2047-8*i -: 8].
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox_lookup(logic [7:0] b);
    logic [10:0] base;
    base = {3'b000, ~b} << 3;
    return SBOX_TBL[base +: 8];
  endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One combinational AES encryption round; last_i skips MixColumns for round 10.
module aes_enc_round
  import aes_pkg::*;
(
  input  state_t state,
  input  state_t round_key,
  input  logic   last_i,
  output state_t next_state
);

  state_t sub_s, shift_s, mix_s;

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      aes_sbox u_sbox (
        .a (state[byte_lsb(r, c) +: 8]),
        .y (sub_s[byte_lsb(r, c) +: 8])
      );
      // Row r rotates left by r columns.
      assign shift_s[byte_lsb(r, c) +: 8] = sub_s[byte_lsb(r, (c + r) % 4) +: 8];
    end

    aes_mixw u_mixw (
      .w (shift_s[col_lsb(c) +: 32]),
      .y (mix_s[col_lsb(c) +: 32])
    );
  end

  assign next_state = (last_i ? shift_s : mix_s) ^ round_key;

endmodule

// File: rtl/aes_key_shedualing.sv
// One step of the forward AES-128 key schedule: round key i -> round key i+1.
module aes_key_shedualing
  import aes_pkg::*;
(
  input  logic [127:0] key,
  input  logic [7:0]   rcon,
  output logic [127:0] next_key
);

  logic [31:0] rot_w, sub_w, w0, w1, w2, w3;

  // RotWord on the last word: byte 1 moves to byte 0, byte 0 wraps to byte 3.
  assign rot_w = {key[103:96], key[127:104]};

  for (genvar i = 0; i < 4; i++) begin : g_sub
    aes_sbox u_sbox (
      .a (rot_w[8*i +: 8]),
      .y (sub_w[8*i +: 8])
    );
  end

  assign w0 = key[31:0] ^ sub_w ^ {24'h000000, rcon};
  assign w1 = key[63:32] ^ w0;
  assign w2 = key[95:64] ^ w1;
  assign w3 = key[127:96] ^ w2;

  assign next_key = {w3, w2, w1, w0};

endmodule

// File: rtl/aes_mixw.sv
// MixColumns on one 32-bit column; byte r of the column is w[8r +: 8].
module aes_mixw
  import aes_pkg::*;
(
  input  logic [31:0] w,
  output logic [31:0] y
);

  logic [7:0] a0, a1, a2, a3;

  assign a0 = w[7:0];
  assign a1 = w[15:8];
  assign a2 = w[23:16];
  assign a3 = w[31:24];

  assign y[7:0]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
  assign y[15:8]  = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
  assign y[23:16] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
  assign y[31:24] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);

endmodule

// File: rtl/aes_sbox.sv
// Forward AES S-box, one byte, combinational.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);

  assign y = sbox_lookup(a);

endmodule

// File: rtl/aes_enc_iter.sv
// Iterative AES-128 encryptor, one round per clock, key schedule expanded on the fly.
// Define AES_ENC_LASTKEY_EN to export the round-10 key on lastkey_o.
module aes_enc_iter
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         data_v_i,
  input  logic [127:0] data_i,
  input  logic [127:0] key_i,
  output logic         ready_o,
  output logic         res_v_o,
  output logic [127:0] res_o
`ifdef AES_ENC_LASTKEY_EN
  ,
  output logic [127:0] lastkey_o
`endif
);

  // Handshake: a block is taken on a rising edge where data_v_i=1 and ready_o=1;
  // data_v_i while ready_o=0 is ignored. res_v_o is a one-cycle pulse with no backpressure.

  fsm_t       fsm_q, fsm_d;
  state_t     data_q, data_d;
  state_t     key_q, key_d;
  logic [7:0] rcon_q, rcon_d;

  logic       accept;
  state_t     round_out;
  state_t     ks_key, ks_next;
  logic [7:0] ks_rcon;

  assign ready_o = (fsm_q == ST_IDLE) || (fsm_q == ST_DONE);
  assign accept  = data_v_i && ready_o;
  assign res_v_o = (fsm_q == ST_DONE);
  assign res_o   = data_q;

`ifdef AES_ENC_LASTKEY_EN
  assign lastkey_o = key_q;
`endif

  // On accept the schedule starts from key_i so key_q already holds round key 1.
  assign ks_key  = accept ? key_i : key_q;
  assign ks_rcon = accept ? RCON_INIT : rcon_q;

  aes_key_shedualing u_keysched (
    .key      (ks_key),
    .rcon     (ks_rcon),
    .next_key (ks_next)
  );

  aes_enc_round u_round (
    .state      (data_q),
    .round_key  (key_q),
    .last_i     (fsm_q == ST_FINAL),
    .next_state (round_out)
  );

  always_comb begin
    fsm_d  = fsm_q;
    data_d = data_q;
    key_d  = key_q;
    rcon_d = rcon_q;
    case (fsm_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          fsm_d  = ST_R1;
          data_d = data_i ^ key_i;
          key_d  = ks_next;
          rcon_d = xtime(RCON_INIT);
        end else begin
          fsm_d = ST_IDLE;
        end
      end
      ST_R1, ST_R2, ST_R3, ST_R4, ST_R5, ST_R6, ST_R7, ST_R8, ST_R9: begin
        fsm_d  = fsm_t'(fsm_q + 4'd1);
        data_d = round_out;
        key_d  = ks_next;
        rcon_d = xtime(rcon_q);
      end
      // Key and rcon hold here, leaving round key 10 visible in the done state.
      ST_FINAL: begin
        fsm_d  = ST_DONE;
        data_d = round_out;
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q  <= ST_IDLE;
      data_q <= '0;
      key_q  <= '0;
      rcon_q <= '0;
    end else begin
      fsm_q  <= fsm_d;
      data_q <= data_d;
      key_q  <= key_d;
      rcon_q <= rcon_d;
    end
  end

endmodule

// File: tb/tb_aes_enc_iter.sv
// Self-checking bench for aes_enc_iter against a byte-array AES-128 model.
// Covers AES_ENC_LASTKEY_EN when that macro is defined.
module tb_aes_enc_iter;

  logic         clk;
  logic         reset;
  logic         data_v_i;
  logic [127:0] data_i;
  logic [127:0] key_i;
  logic         ready_o;
  logic         res_v_o;
  logic [127:0] res_o;
`ifdef AES_ENC_LASTKEY_EN
  logic [127:0] lastkey_o;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0]   tb_sbox [256];
  logic [127:0] exp_q [$];
  logic [127:0] exp_k_q [$];

  aes_enc_iter dut (
    .clk       (clk),
    .reset     (reset),
    .data_v_i  (data_v_i),
    .data_i    (data_i),
    .key_i     (key_i),
    .ready_o   (ready_o),
    .res_v_o   (res_v_o),
    .res_o     (res_o)
`ifdef AES_ENC_LASTKEY_EN
    ,
    .lastkey_o (lastkey_o)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(logic [7:0] x, int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // S-box derived from the GF(2^8) inverse and the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      tb_sbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic ref_aes(input logic [127:0] pt, input logic [127:0] key,
                         output logic [127:0] ct, output logic [127:0] lk);
    logic [7:0] st [16];
    logic [7:0] tmp [16];
    logic [7:0] w [44][4];
    logic [7:0] t [4];
    logic [7:0] rc, t0;
    for (int i = 0; i < 16; i++) st[i] = pt[8*i +: 8];
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) w[i][j] = key[8*(4*i+j) +: 8];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      for (int j = 0; j < 4; j++) t[j] = w[i-1][j];
      if (i % 4 == 0) begin
        t0 = t[0];
        t[0] = tb_sbox[t[1]] ^ rc;
        t[1] = tb_sbox[t[2]];
        t[2] = tb_sbox[t[3]];
        t[3] = tb_sbox[t0];
        rc = gmul(rc, 8'h02);
      end
      for (int j = 0; j < 4; j++) w[i][j] = w[i-4][j] ^ t[j];
    end
    for (int r = 0; r <= 10; r++) begin
      if (r > 0) begin
        for (int i = 0; i < 16; i++) st[i] = tb_sbox[st[i]];
        for (int c = 0; c < 4; c++)
          for (int rr = 0; rr < 4; rr++) tmp[4*c+rr] = st[4*((c+rr)%4)+rr];
        st = tmp;
        if (r < 10) begin
          for (int c = 0; c < 4; c++) begin
            tmp[4*c+0] = gmul(st[4*c], 2) ^ gmul(st[4*c+1], 3) ^ st[4*c+2] ^ st[4*c+3];
            tmp[4*c+1] = st[4*c] ^ gmul(st[4*c+1], 2) ^ gmul(st[4*c+2], 3) ^ st[4*c+3];
            tmp[4*c+2] = st[4*c] ^ st[4*c+1] ^ gmul(st[4*c+2], 2) ^ gmul(st[4*c+3], 3);
            tmp[4*c+3] = gmul(st[4*c], 3) ^ st[4*c+1] ^ st[4*c+2] ^ gmul(st[4*c+3], 2);
          end
          st = tmp;
        end
      end
      for (int c = 0; c < 4; c++)
        for (int j = 0; j < 4; j++) st[4*c+j] = st[4*c+j] ^ w[4*r+c][j];
    end
    for (int i = 0; i < 16; i++) ct[8*i +: 8] = st[i];
    for (int c = 0; c < 4; c++)
      for (int j = 0; j < 4; j++) lk[32*c+8*j +: 8] = w[40+c][j];
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Present one block at the current negedge; the next rising edge takes it.
  task automatic send(input logic [127:0] pt, input logic [127:0] key);
    data_v_i = 1'b1;
    data_i   = pt;
    key_i    = key;
    tick();
    data_v_i = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; data_v_i = 1'b0; data_i = '0; key_i = '0;
    tick(); tick();
    reset = 1'b0;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
    checks++; if (res_v_o !== 1'b0) begin errors++; $display("FAIL reset_res_v got=%b exp=0", res_v_o); end
    checks++; if (res_o !== 128'h0) begin errors++; $display("FAIL reset_res got=%h exp=0", res_o); end
`ifdef AES_ENC_LASTKEY_EN
    checks++; if (lastkey_o !== 128'h0) begin errors++; $display("FAIL reset_lastkey got=%h exp=0", lastkey_o); end
`endif
  endtask

  task automatic test_fips();
    logic [127:0] k = 128'h0f0e0d0c0b0a09080706050403020100;
    logic [127:0] p = 128'hffeeddccbbaa99887766554433221100;
    send(p, k);
    for (int n = 1; n <= 10; n++) begin
      checks++; if (res_v_o !== 1'b0) begin errors++; $display("FAIL fips_early_res_v cyc=%0d got=%b exp=0", n, res_v_o); end
      checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL fips_busy_ready cyc=%0d got=%b exp=0", n, ready_o); end
      tick();
    end
    checks++; if (res_v_o !== 1'b1) begin errors++; $display("FAIL fips_res_v got=%b exp=1", res_v_o); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL fips_done_ready got=%b exp=1", ready_o); end
    checks++; if (res_o !== 128'h5ac5b47080b7cdd830047b6ad8e0c469) begin
      errors++; $display("FAIL fips_res got=%h exp=5ac5b47080b7cdd830047b6ad8e0c469", res_o);
    end
`ifdef AES_ENC_LASTKEY_EN
    checks++; if (lastkey_o !== 128'hc5302b4d8ba707f3174a94e37f1d1113) begin
      errors++; $display("FAIL fips_lastkey got=%h exp=c5302b4d8ba707f3174a94e37f1d1113", lastkey_o);
    end
`endif
    tick();
    checks++; if (res_v_o !== 1'b0) begin errors++; $display("FAIL fips_pulse_width got=%b exp=0", res_v_o); end
  endtask

  task automatic test_ignore_busy();
    logic [127:0] p = rand128(), k = rand128(), ct, lk;
    ref_aes(p, k, ct, lk);
    send(p, k);
    repeat (4) tick();
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL ignore_ready got=%b exp=0", ready_o); end
    data_v_i = 1'b1; data_i = rand128(); key_i = rand128();
    tick();
    data_v_i = 1'b0;
    repeat (5) tick();
    checks++; if (res_v_o !== 1'b1) begin errors++; $display("FAIL ignore_res_v got=%b exp=1", res_v_o); end
    checks++; if (res_o !== ct) begin errors++; $display("FAIL ignore_res got=%h exp=%h", res_o, ct); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [127:0] pa = rand128(), ka = rand128(), pb = rand128(), kb = rand128();
    logic [127:0] cta, lka, ctb, lkb;
    int gap = 0;
    ref_aes(pa, ka, cta, lka);
    ref_aes(pb, kb, ctb, lkb);
    send(pa, ka);
    repeat (10) tick();
    checks++; if (res_v_o !== 1'b1) begin errors++; $display("FAIL b2b_first_res_v got=%b exp=1", res_v_o); end
    checks++; if (res_o !== cta) begin errors++; $display("FAIL b2b_first_res got=%h exp=%h", res_o, cta); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready got=%b exp=1", ready_o); end
    send(pb, kb);
    gap = 1;
    while (!res_v_o && gap < 20) begin
      tick();
      gap++;
    end
    checks++; if (gap !== 11) begin errors++; $display("FAIL b2b_spacing got=%0d exp=11", gap); end
    checks++; if (res_o !== ctb) begin errors++; $display("FAIL b2b_second_res got=%h exp=%h", res_o, ctb); end
`ifdef AES_ENC_LASTKEY_EN
    checks++; if (lastkey_o !== lkb) begin errors++; $display("FAIL b2b_lastkey got=%h exp=%h", lastkey_o, lkb); end
`endif
    tick();
  endtask

  task automatic test_reset_mid();
    logic [127:0] p = rand128(), k = rand128(), ct, lk;
    int stray = 0;
    send(rand128(), rand128());
    repeat (5) tick();
    reset = 1'b1; data_v_i = 1'b1; data_i = rand128(); key_i = rand128();
    tick();
    reset = 1'b0; data_v_i = 1'b0;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%b exp=1", ready_o); end
    checks++; if (res_o !== 128'h0) begin errors++; $display("FAIL midrst_res got=%h exp=0", res_o); end
    for (int n = 0; n < 14; n++) begin
      if (res_v_o !== 1'b0) stray++;
      tick();
    end
    checks++; if (stray !== 0) begin errors++; $display("FAIL midrst_no_pulse got=%0d pulses exp=0", stray); end
    ref_aes(p, k, ct, lk);
    send(p, k);
    repeat (10) tick();
    checks++; if (res_v_o !== 1'b1) begin errors++; $display("FAIL midrst_fresh_res_v got=%b exp=1", res_v_o); end
    checks++; if (res_o !== ct) begin errors++; $display("FAIL midrst_fresh_res got=%h exp=%h", res_o, ct); end
    tick();
  endtask

  task automatic test_random();
    localparam int N_BLOCKS = 1000;
    logic [127:0] p, k, ct, lk, e, ek;
    int sent = 0, got = 0, gap = 0, cycles = 0;
    exp_q.delete();
    exp_k_q.delete();
    gap = $urandom_range(0, 3);
    while ((sent < N_BLOCKS || exp_q.size() != 0) && cycles < 20000) begin
      if (res_v_o === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_unexpected_result got=%h", res_o);
        end else begin
          e = exp_q.pop_front();
          ek = exp_k_q.pop_front();
          got++;
          if (res_o !== e) begin errors++; $display("FAIL rand_res blk=%0d got=%h exp=%h", got, res_o, e); end
`ifdef AES_ENC_LASTKEY_EN
          checks++;
          if (lastkey_o !== ek) begin errors++; $display("FAIL rand_lastkey blk=%0d got=%h exp=%h", got, lastkey_o, ek); end
`endif
        end
      end
      if (sent < N_BLOCKS && gap == 0 && ready_o === 1'b1) begin
        p = rand128(); k = rand128();
        ref_aes(p, k, ct, lk);
        exp_q.push_back(ct);
        exp_k_q.push_back(lk);
        data_v_i = 1'b1; data_i = p; key_i = k;
        sent++;
        gap = $urandom_range(0, 3);
      end else if (ready_o === 1'b0 && $urandom_range(0, 3) == 0) begin
        data_v_i = 1'b1; data_i = rand128(); key_i = rand128();
      end else begin
        data_v_i = 1'b0;
        if (gap > 0) gap--;
      end
      tick();
      cycles++;
    end
    data_v_i = 1'b0;
    checks++; if (got !== N_BLOCKS) begin errors++; $display("FAIL rand_count got=%0d exp=%0d", got, N_BLOCKS); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1; data_v_i = 1'b0; data_i = '0; key_i = '0;
    build_sbox();
    @(negedge clk);
    test_reset();
    test_fips();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
